// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator keypad front-end.
package calc_pkg;

  typedef enum logic [3:0] {
    ENTER_A  = 4'd0,
    ENTER_OP = 4'd1,
    ENTER_B  = 4'd2,
    WR_A     = 4'd3,
    WR_OP    = 4'd4,
    WR_B     = 4'd5,
    RUN      = 4'd6,
    RD_RES   = 4'd7,
    CONV     = 4'd8,
    SHOW     = 4'd9,
    ERROR    = 4'd10
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  localparam logic [4:0] KEY_BS  = 5'd10;
  localparam logic [4:0] KEY_CLR = 5'd11;
  localparam logic [4:0] KEY_ENT = 5'd12;
  localparam logic [4:0] KEY_OP0 = 5'd16;

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble: one result bit per cycle, done pulses after RES_W shifts.
module bin2bcd_seq #(
  parameter int RES_W = 16,
  parameter int ND    = 10
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start_i,
  input  logic [RES_W-1:0] bin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [4*ND-1:0]  bcd_o
);
  localparam int CW = $clog2(RES_W + 1);

  logic [RES_W-1:0] sh_q;
  logic [4*ND-1:0]  bcd_q, adj;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q;

  // Add-3 correction on every nibble >= 5 before the shift.
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < ND; i++)
      if (bcd_q[4*i +: 4] > 4'd4) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sh_q   <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        sh_q   <= bin_i;
        bcd_q  <= '0;
        cnt_q  <= CW'(RES_W);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        bcd_q <= {adj[4*ND-2:0], sh_q[RES_W-1]};
        sh_q  <= sh_q << 1;
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/calc_entry_ctrl.sv
// Keypad operand/operator entry, CPU data-memory handoff, run supervision and
// result-to-BCD display path for the FPGA calculator.
module calc_entry_ctrl
  import calc_pkg::*;
#(
  parameter int          DIGITS      = 2,
  parameter int          RES_W       = 16,
  parameter logic [31:0] ADDR_A      = 32'd220,
  parameter logic [31:0] ADDR_B      = 32'd240,
  parameter logic [31:0] ADDR_OP     = 32'd260,
  parameter logic [31:0] ADDR_RES    = 32'd280,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic                                  clk,
  input  logic                                  nrst,
  input  logic                                  key_valid,
  input  logic [4:0]                            key_code,
  input  logic                                  cpu_done,
  input  logic                                  bus_ack,
  input  logic [31:0]                           bus_rdata,
  output logic                                  bus_req,
  output logic                                  bus_we,
  output logic [31:0]                           bus_addr,
  output logic [31:0]                           bus_wdata,
  output logic                                  cpu_en,
  output logic [4*((DIGITS > 10) ? DIGITS : 10)-1:0] disp_bcd,
  output logic [3:0]                            disp_state,
  output logic                                  err
);
  localparam int ND = (DIGITS > 10) ? DIGITS : 10;
  localparam int BW = 4 * DIGITS;
  localparam int DW = 4 * ND;

  function automatic logic [31:0] bcd2bin(input logic [BW-1:0] b);
    logic [31:0] v;
    v = '0;
    for (int i = DIGITS - 1; i >= 0; i--) v = v * 32'd10 + 32'(b[4*i +: 4]);
    return v;
  endfunction

  state_e        state_q, state_d, tgt_next;
  logic [BW-1:0] a_q, a_d, b_q, b_d;
  op_e           op_q, op_d;
  logic          opv_q, opv_d, err_q, err_d;
  logic          req_q, req_d, we_q, we_d, tgt_we;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, tgt_addr, tgt_wdata;
  logic [31:0]   tmo_q, tmo_d;
  logic          is_dig, is_op, key_clr;
  logic          conv_start, conv_busy, conv_done;
  logic [DW-1:0] conv_bcd;
  logic          rdata_unused;

  assign rdata_unused = ^{1'b0, bus_rdata};
  assign is_dig  = key_code < 5'd10;
  assign is_op   = key_code[4:2] == KEY_OP0[4:2];
  assign key_clr = key_valid && key_code == KEY_CLR &&
                   state_q inside {ENTER_A, ENTER_OP, ENTER_B, SHOW, ERROR};
  assign conv_start = state_q == RD_RES && req_q && bus_ack && !conv_busy;

  // Address/data/successor of the transfer owned by the current bus state.
  always_comb begin
    tgt_addr  = ADDR_RES;
    tgt_we    = 1'b0;
    tgt_wdata = '0;
    tgt_next  = CONV;
    case (state_q)
      WR_A:    begin tgt_addr = ADDR_A;  tgt_we = 1'b1; tgt_wdata = bcd2bin(a_q);   tgt_next = WR_OP; end
      WR_OP:   begin tgt_addr = ADDR_OP; tgt_we = 1'b1; tgt_wdata = {30'b0, op_q}; tgt_next = WR_B;  end
      WR_B:    begin tgt_addr = ADDR_B;  tgt_we = 1'b1; tgt_wdata = bcd2bin(b_q);   tgt_next = RUN;   end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    opv_d   = opv_q;
    err_d   = err_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    tmo_d   = tmo_q;
    case (state_q)
      ENTER_A: if (key_valid) begin
        if (is_dig)                 a_d = (a_q << 4) | BW'(key_code[3:0]);
        else if (key_code == KEY_BS) a_d = a_q >> 4;
        else if (key_code == KEY_ENT) state_d = ENTER_OP;
      end
      ENTER_OP: if (key_valid) begin
        if (key_code == KEY_BS) opv_d = 1'b0;
        else if (is_op) begin
          op_d  = op_e'(key_code[1:0]);
          opv_d = 1'b1;
        end else if (key_code == KEY_ENT && opv_q) state_d = ENTER_B;
      end
      ENTER_B: if (key_valid) begin
        if (is_dig)                 b_d = (b_q << 4) | BW'(key_code[3:0]);
        else if (key_code == KEY_BS) b_d = b_q >> 4;
        else if (key_code == KEY_ENT) state_d = WR_A;
      end
      // One idle cycle with req low on entry guarantees the inter-transfer gap.
      WR_A, WR_OP, WR_B, RD_RES: begin
        if (req_q && bus_ack) begin
          req_d   = 1'b0;
          state_d = tgt_next;
          tmo_d   = '0;
        end else if (!req_q) begin
          req_d   = 1'b1;
          we_d    = tgt_we;
          addr_d  = tgt_addr;
          wdata_d = tgt_wdata;
        end
      end
      RUN: begin
        if (cpu_done) state_d = RD_RES;
        else if (TIMEOUT_CYC != 0 && tmo_q == 32'(TIMEOUT_CYC - 1)) begin
          state_d = ERROR;
          err_d   = 1'b1;
        end else tmo_d = tmo_q + 32'd1;
      end
      CONV: if (conv_done) state_d = SHOW;
      SHOW, ERROR: if (key_valid && key_code == KEY_ENT) begin
        state_d = ENTER_A;
        a_d     = '0;
        b_d     = '0;
        opv_d   = 1'b0;
        err_d   = 1'b0;
      end
      default: state_d = ENTER_A;
    endcase
    if (key_clr) begin
      state_d = ENTER_A;
      a_d     = '0;
      b_d     = '0;
      opv_d   = 1'b0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ENTER_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ADD;
      opv_q   <= 1'b0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      opv_q   <= opv_d;
      err_q   <= err_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      tmo_q   <= tmo_d;
    end
  end

  bin2bcd_seq #(.RES_W(RES_W), .ND(ND)) u_b2b (
    .clk     (clk),
    .nrst    (nrst),
    .start_i (conv_start),
    .bin_i   (bus_rdata[RES_W-1:0]),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd)
  );

  always_comb begin
    disp_bcd = '0;
    case (state_q)
      ENTER_A, ENTER_OP: begin
        disp_bcd[BW-1:0] = a_q;
        if (opv_q) disp_bcd[DW-1 -: 4] = {2'b00, op_q};
      end
      ENTER_B: disp_bcd[BW-1:0] = b_q;
      SHOW:    disp_bcd = conv_bcd;
      ERROR:   disp_bcd = '1;
      default: ;
    endcase
  end

  assign bus_req    = req_q;
  assign bus_we     = we_q;
  assign bus_addr   = addr_q;
  assign bus_wdata  = wdata_q;
  assign cpu_en     = state_q == RUN;
  assign disp_state = state_q;
  assign err        = err_q;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Bench for calc_entry_ctrl: key-entry vector table, randomized keys against a
// decimal reference model, and bus/run/timeout/reset sequences.
module tb_calc_entry_ctrl;
  import calc_pkg::*;

  localparam int DIGITS = 2;
  localparam int MOD    = 100;

  logic        clk = 1'b0, nrst;
  logic        key_valid, cpu_done, bus_ack, bus_req, bus_we, cpu_en, err;
  logic [4:0]  key_code;
  logic [31:0] bus_rdata, bus_addr, bus_wdata;
  logic [39:0] disp_bcd;
  logic [3:0]  disp_state;

  calc_entry_ctrl #(.DIGITS(DIGITS), .RES_W(16), .TIMEOUT_CYC(100)) dut (
    .clk(clk), .nrst(nrst), .key_valid(key_valid), .key_code(key_code),
    .cpu_done(cpu_done), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .cpu_en(cpu_en), .disp_bcd(disp_bcd), .disp_state(disp_state), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct { logic [31:0] addr; logic we; logic [31:0] wd; } txn_t;
  txn_t        txlog[$];
  logic [31:0] block_addr = 32'hFFFF_FFFF;
  logic [31:0] rd_val = '0;

  // Memory-side responder: random 0-5 cycle ack delay, checks request stability.
  initial begin : responder
    int dly;
    bit pend;
    txn_t t;
    bus_ack = 1'b0; bus_rdata = '0; pend = 0; dly = 0;
    forever begin
      @(posedge clk); #1;
      if (!nrst) begin
        bus_ack = 1'b0; pend = 0;
      end else if (bus_ack) begin
        bus_ack = 1'b0; pend = 0;
        chk("req_gap", bus_req, 1'b0);
      end else if (bus_req && bus_addr != block_addr) begin
        if (!pend) begin
          pend = 1; dly = $urandom_range(0, 5);
          t.addr = bus_addr; t.we = bus_we; t.wd = bus_wdata;
        end else begin
          chk("hold_addr", bus_addr, t.addr);
          chk("hold_we", bus_we, t.we);
          chk("hold_wdata", bus_wdata, t.wd);
        end
        if (dly == 0) begin
          bus_ack = 1'b1;
          bus_rdata = t.we ? $urandom : rd_val;
          txlog.push_back(t);
        end else dly--;
      end
    end
  end

  task automatic press(input logic [4:0] k);
    key_valid = 1'b1; key_code = k;
    @(posedge clk); #1;
    key_valid = 1'b0; key_code = 5'($urandom);
  endtask

  task automatic wait_state(input state_e s, input int lim, input string nm);
    for (int i = 0; i < lim && disp_state != s; i++) begin @(posedge clk); #1; end
    chk(nm, disp_state, s);
  endtask

  task automatic chk_writes(input int n, input logic [31:0] va, vo, vb);
    logic [31:0] ea[3];
    logic [31:0] ed[3];
    ea[0] = 32'd220; ea[1] = 32'd260; ea[2] = 32'd240;
    ed[0] = va;      ed[1] = vo;      ed[2] = vb;
    chk("n_txn", txlog.size(), n);
    for (int i = 0; i < 3; i++)
      if (txlog.size() > i) begin
        chk("wr_addr", txlog[i].addr, ea[i]);
        chk("wr_we", txlog[i].we, 1'b1);
        chk("wr_data", txlog[i].wd, ed[i]);
      end
  endtask

  // Reference model: operands kept as plain decimal integers.
  int ms, ma, mb, mop;
  bit mopv;

  task automatic model(input int k);
    if (k == 11) begin ms = 0; ma = 0; mb = 0; mopv = 0; end
    else case (ms)
      0: if (k < 10) ma = (ma * 10 + k) % MOD; else if (k == 10) ma = ma / 10; else if (k == 12) ms = 1;
      1: if (k == 10) mopv = 0;
         else if (k >= 16 && k <= 19) begin mop = k - 16; mopv = 1; end
         else if (k == 12 && mopv) ms = 2;
      2: if (k < 10) mb = (mb * 10 + k) % MOD; else if (k == 10) mb = mb / 10;
      default: ;
    endcase
  endtask

  function automatic logic [39:0] to_bcd(input int v);
    logic [39:0] d;
    d = '0;
    for (int i = 0; i < 10; i++) begin d[4*i +: 4] = 4'(v % 10); v = v / 10; end
    return d;
  endfunction

  function automatic logic [39:0] model_disp();
    logic [39:0] d;
    if (ms == 2) d = to_bcd(mb);
    else begin
      d = to_bcd(ma);
      if (mopv) d[39:36] = 4'(mop);
    end
    return d;
  endfunction

  function automatic logic [3:0] model_state();
    return (ms == 0) ? ENTER_A : (ms == 1) ? ENTER_OP : ENTER_B;
  endfunction

  typedef struct { logic [4:0] key; logic [3:0] st; logic [39:0] disp; } vec_t;
  vec_t tv[16];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int n, n_conv, k;
    nrst = 1'b0; key_valid = 1'b0; key_code = '0; cpu_done = 1'b0;
    tv[0]  = '{5'd1,  ENTER_A,  40'h1};
    tv[1]  = '{5'd2,  ENTER_A,  40'h12};
    tv[2]  = '{5'd3,  ENTER_A,  40'h23};
    tv[3]  = '{5'd10, ENTER_A,  40'h02};
    tv[4]  = '{5'd12, ENTER_OP, 40'h02};
    tv[5]  = '{5'd12, ENTER_OP, 40'h02};
    tv[6]  = '{5'd7,  ENTER_OP, 40'h02};
    tv[7]  = '{5'd19, ENTER_OP, 40'h30_0000_0002};
    tv[8]  = '{5'd13, ENTER_OP, 40'h30_0000_0002};
    tv[9]  = '{5'd17, ENTER_OP, 40'h10_0000_0002};
    tv[10] = '{5'd10, ENTER_OP, 40'h02};
    tv[11] = '{5'd19, ENTER_OP, 40'h30_0000_0002};
    tv[12] = '{5'd12, ENTER_B,  40'h0};
    tv[13] = '{5'd8,  ENTER_B,  40'h8};
    tv[14] = '{5'd25, ENTER_B,  40'h8};
    tv[15] = '{5'd11, ENTER_A,  40'h0};

    repeat (2) @(posedge clk); #1;
    chk("rst_state", disp_state, ENTER_A);
    chk("rst_req", bus_req, 1'b0);
    chk("rst_we", bus_we, 1'b0);
    chk("rst_cpu_en", cpu_en, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    chk("rst_disp", disp_bcd, 40'd0);
    nrst = 1'b1;
    @(posedge clk); #1;

    foreach (tv[i]) begin
      press(tv[i].key);
      chk($sformatf("tv%0d_state", i), disp_state, tv[i].st);
      chk($sformatf("tv%0d_disp", i), disp_bcd, tv[i].disp);
    end

    ms = 0; ma = 0; mb = 0; mop = 0; mopv = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        key_code = 5'($urandom);
        @(posedge clk); #1;
      end else begin
        k = $urandom_range(0, 31);
        if (ms == 2 && k == 12) k = 11;
        model(k);
        press(5'(k));
      end
      chk("rnd_state", disp_state, model_state());
      chk("rnd_disp", disp_bcd, model_disp());
    end
    press(KEY_CLR);

    // Full run: 42 op1 7, CPU finishes after 50 cycles, result 1234.
    txlog.delete(); rd_val = 32'h0000_04D2;
    press(4); press(2); press(KEY_ENT); press(17); press(KEY_ENT); press(7); press(KEY_ENT);
    wait_state(RUN, 200, "reach_run");
    chk("run_cpu_en", cpu_en, 1'b1);
    press(KEY_CLR);
    chk("run_ignores_key", disp_state, RUN);
    repeat (49) @(posedge clk);
    #1 cpu_done = 1'b1;
    n_conv = 0;
    for (int i = 0; i < 300 && disp_state != SHOW; i++) begin
      @(posedge clk); #1;
      if (disp_state != RUN) cpu_done = 1'b0;
      if (disp_state == CONV) n_conv++;
    end
    cpu_done = 1'b0;
    chk("show_state", disp_state, SHOW);
    chk("conv_cycles", n_conv, 17);
    chk("show_disp", disp_bcd, 40'h1234);
    chk("show_cpu_en", cpu_en, 1'b0);
    chk("show_err", err, 1'b0);
    chk_writes(4, 32'd42, 32'd1, 32'd7);
    if (txlog.size() == 4) begin
      chk("rd_addr", txlog[3].addr, 32'd280);
      chk("rd_we", txlog[3].we, 1'b0);
    end
    press(KEY_ENT);
    chk("show_ent_state", disp_state, ENTER_A);
    chk("show_ent_disp", disp_bcd, 40'h0);

    // Timeout: cpu_done never arrives.
    txlog.delete();
    press(1); press(KEY_ENT); press(16); press(KEY_ENT); press(2); press(KEY_ENT);
    wait_state(RUN, 200, "reach_run_to");
    n = 0;
    for (int i = 0; i < 200 && disp_state == RUN; i++) begin @(posedge clk); #1; n++; end
    chk("timeout_cycles", n, 100);
    chk("timeout_state", disp_state, ERROR);
    chk("timeout_err", err, 1'b1);
    chk("timeout_disp", disp_bcd, 40'hFF_FFFF_FFFF);
    chk("timeout_cpu_en", cpu_en, 1'b0);
    chk_writes(3, 32'd1, 32'd0, 32'd2);
    press(KEY_CLR);
    chk("err_clr_state", disp_state, ENTER_A);
    chk("err_clr_err", err, 1'b0);

    // Asynchronous reset with the WR_B request outstanding.
    block_addr = 32'd240;
    press(3); press(KEY_ENT); press(18); press(KEY_ENT); press(4); press(KEY_ENT);
    for (int i = 0; i < 200 && !(bus_req && bus_addr == 32'd240); i++) begin @(posedge clk); #1; end
    chk("wrb_req_up", bus_req, 1'b1);
    chk("wrb_state", disp_state, WR_B);
    #2 nrst = 1'b0;
    #1;
    chk("arst_req", bus_req, 1'b0);
    chk("arst_cpu_en", cpu_en, 1'b0);
    @(posedge clk); #1;
    nrst = 1'b1; block_addr = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    chk("arst_state", disp_state, ENTER_A);
    chk("arst_req_after", bus_req, 1'b0);
    chk("arst_disp", disp_bcd, 40'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_entry_ctrl.md
# calc_entry_ctrl

Parametrised keypad front-end for the FPGA calculator. It collects two decimal operands of DIGITS digits and one operator from debounced key strobes, and writes them to CPU data memory through a req/ack bus. It then hands control to the CPU, waits for the completion flag with a timeout, reads back the result and converts it to BCD for display. It sits between the keypad synchroniser and the CPU data-memory arbiter.

## Interface
- DIGITS, 2: decimal digits per operand (1..8)
- RES_W, 16: result bits converted for display (≤32)
- ADDR_A, 220: operand A word address
- ADDR_B, 240: operand B word address
- ADDR_OP, 260: operator word address
- ADDR_RES, 280: result word address
- TIMEOUT_CYC, 1_000_000: CPU run-cycle limit; 0 disables the timeout
- clk  in  1  clock
- nrst  in  1  reset, asynchronous, active-low
- key_valid  in  1  single-cycle key strobe
- key_code  in  5  0-9 digit, 10 backspace, 11 clear, 12 enter, 16-19 operator 0-3
- cpu_done  in  1  CPU completion flag (instruction == 32'hFFFFFFFF), level
- bus_ack  in  1  bus transfer complete
- bus_rdata  in  32  read data, valid with bus_ack
- bus_req  out  1  transfer request
- bus_we  out  1  1 = write, 0 = read
- bus_addr  out  32  transfer address
- bus_wdata  out  32  write data
- cpu_en  out  1  CPU run enable
- disp_bcd  out  4*max(DIGITS,10)  BCD digits for the seven-segment drivers, LS digit in [3:0]
- disp_state  out  4  current state encoding
- err  out  1  timeout indication

## Operation
- States: ENTER_A, ENTER_OP, ENTER_B, WR_A, WR_OP, WR_B, RUN, RD_RES, CONV, SHOW, ERROR.
- Digit key (ENTER_A/ENTER_B): shift the current BCD buffer left one nibble and insert the digit. When the buffer is full, the MS digit is discarded.
- Backspace: shift the current buffer right, inserting 0 at the MS nibble. In ENTER_OP, backspace clears op_valid.
- Clear (any entry state, SHOW or ERROR): zero both buffers, clear op_valid and err, go to ENTER_A.
- Operator key (ENTER_OP only): latch op = key_code-16 and set op_valid. A later operator key overwrites it.
- Enter transitions:
  - ENTER_A→ENTER_OP.
  - ENTER_OP→ENTER_B only if op_valid; otherwise ignored.
  - ENTER_B→WR_A.
  - SHOW→ENTER_A (buffers cleared).
  - ERROR→ENTER_A.
- Write data:
  - WR_A writes the binary value of buffer A (Horner, combinational).
  - WR_OP writes {30'b0, op}.
  - WR_B writes the binary value of buffer B.
- RUN: cpu_en = 1. cpu_done high → RD_RES. Timeout counter reaching TIMEOUT_CYC → ERROR with err = 1.
- RD_RES: read ADDR_RES and capture bus_rdata[RES_W-1:0] on bus_ack → CONV.
- CONV: iterative double-dabble by sub-module, one bit per cycle. On completion → SHOW.
- Display:
  - ENTER_A/ENTER_OP show buffer A, with op in the top nibble when op_valid.
  - ENTER_B shows buffer B.
  - SHOW shows the converted result.
  - ERROR shows all-ones nibbles.
- Ignored inputs:
  - Keys are ignored in the WR_*, RUN, RD_RES and CONV states.
  - cpu_done is ignored outside RUN.
  - key_code values 13-15 and 20-31 are ignored.

## Timing
- Reset values:
  - state ENTER_A; buffers 0; op_valid 0.
  - bus_req, bus_we, cpu_en, err all 0.
  - bus_addr and bus_wdata 0; disp_bcd 0.
- Key effects are registered: visible on the cycle after key_valid.
- Bus handshake:
  - bus_req asserts the cycle after entering a WR_*/RD_RES state.
  - bus_addr, bus_wdata and bus_we are held stable while bus_req is high.
  - The transfer completes on the first clock edge with bus_req && bus_ack.
  - bus_req deasserts for at least one cycle between transfers.
  - bus_ack without bus_req is ignored.
- The timeout counter clears on RUN entry and increments each RUN cycle. ERROR is entered on the cycle count == TIMEOUT_CYC. If cpu_done and the timeout occur in the same cycle, cpu_done wins.
- cpu_en deasserts on the cycle after leaving RUN.
- CONV takes exactly RES_W+1 cycles.
- nrst assertion mid-transfer drops bus_req and cpu_en immediately (asynchronous).
- A key_valid coincident with a state transition is evaluated in the pre-transition state only.

## Structure
- Package calc_pkg holds:
  - the state enum;
  - key code constants (KEY_BS=10, KEY_CLR=11, KEY_ENT=12, KEY_OP0=16);
  - operator encodings.
- Sub-module bin2bcd_seq: start/busy/done, iterative double-dabble, width parameter RES_W.
- BCD→binary conversion for the operands is an in-module function.

## Test plan
- Enter 4,2, op 1 (key 17), 7, enter with DIGITS=2 → writes 42@220, 1@260, 7@240, in that order, with the bus_ack delay randomised 0-5 cycles.
- Enter 1,2,3 in ENTER_A with DIGITS=2 → buffer shows 23. Then backspace → buffer shows 02.
- Enter in ENTER_OP with no operator → state remains ENTER_OP. Then key 19, enter → ENTER_B, op = 3.
- Full run with cpu_done after 50 cycles and rdata 0x0000_04D2 → SHOW with disp_bcd = …1234.
- TIMEOUT_CYC=100, cpu_done held low → err = 1 and state ERROR exactly 100 RUN cycles after entry. Clear → ENTER_A.
- nrst pulse while bus_req is high in WR_B → bus_req=0 and cpu_en=0 immediately, with state ENTER_A after release.
